rx: RTL

Serial receiver for the 162-bit frame format produced by the board's serial transmitter. It sits directly downstream of that transmitter on the single-wire link. It recovers the start/data/stop framing by mid-bit sampling at a fixed clock divisor and presents the 162-bit payload in parallel with a one-cycle valid strobe. Framing errors are flagged and never update the payload.

---
 rtl/rx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rx.sv
// rx -- serial frame receiver.
//
// Recovers a frame of 1 start bit (0), DATA_LNGTH data bits sent LSB first,
// and 1 stop bit (1). Each bit lasts DIVISOR clock cycles. The line is
// sampled at mid-bit, with all timing referenced to the synchronized line.
// A good frame updates val_out. A bad stop bit raises error_out and leaves
// val_out untouched.
//
// Ports:
//   clk_in         system clock
//   rst_n_in       asynchronous active-low reset
//   data_in        serial line, idles high, asynchronous to clk_in
//   val_out        last good payload; val_out[0] is the first data bit received
//   valid_out      1-cycle pulse in the cycle val_out takes a new payload
//   error_out      1-cycle pulse on a framing error (stop bit sampled 0)
//   busy_out       high whenever the receiver is not in IDLE
//   state_dbg_out  current FSM state (IDLE=0 START=1 DATA=2 STOP=3 BREAK=4)
//
// Handshake: valid_out and error_out are single-cycle strobes with no ready
// or back-pressure. A consumer must capture val_out in the cycle valid_out is
// high, or it can read val_out any time later because val_out holds until the
// next good frame. The two strobes are never high in the same cycle.
module rx #(
  parameter int DIVISOR    = 6771,
  parameter int DATA_LNGTH = 162
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  data_in,
  output logic [DATA_LNGTH-1:0] val_out,
  output logic                  valid_out,
  output logic                  error_out,
  output logic                  busy_out,
  output logic [2:0]            state_dbg_out
);

  localparam int CW = $clog2(DIVISOR) + 1;

  // Half a bit from the detected edge to the start-bit sample, then one full
  // bit between samples. Both are loaded as N-1 because the counter fires on 0.
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIVISOR - 1);
  localparam logic [7:0]    LAST_IDX  = 8'(DATA_LNGTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                  sync1_q, sync2_q, prev_q;
  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            idx_q, idx_d;
  logic [DATA_LNGTH-1:0] shift_q, shift_d;
  logic [DATA_LNGTH-1:0] val_q, val_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic                  fall_edge;
  logic                  cnt_zero;

  assign fall_edge = prev_q & ~sync2_q;
  assign cnt_zero  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    val_d   = val_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    // The counter only runs while a bit is being timed. An explicit reload
    // below overrides this decrement.
    if (state_q != S_IDLE && state_q != S_BREAK) begin
      cnt_d = cnt_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (fall_edge) begin
          cnt_d   = HALF_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_zero) begin
          if (!sync2_q) begin
            cnt_d   = BIT_LOAD;
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            // The line went back high before mid start bit: a glitch, not a frame.
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_zero) begin
          // After DATA_LNGTH right shifts, the first bit received is at bit 0.
          shift_d = {sync2_q, shift_q[DATA_LNGTH-1:1]};
          cnt_d   = BIT_LOAD;
          idx_d   = idx_q + 8'd1;
          if (idx_q == LAST_IDX) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (cnt_zero) begin
          if (sync2_q) begin
            val_d   = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Wait here so a line held low is not taken as a new start bit.
        if (sync2_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      val_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      val_q   <= val_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign val_out       = val_q;
  assign valid_out     = valid_q;
  assign error_out     = error_q;
  assign busy_out      = (state_q != S_IDLE);
  assign state_dbg_out = state_q;

endmodule
